// File: rtl/fetch_pkg.sv
// Shared state encoding, opcode values and default widths for the fetch stage
// and the predecoder that later decode logic also reuses.
package fetch_pkg;

  localparam int         DEF_ADDR_W  = 11;
  localparam int         DEF_INSTR_W = 16;
  localparam int         DEF_OFS_W   = 10;
  localparam logic [3:0] DEF_OPC_JSR = 4'hE;
  localparam logic [3:0] DEF_OPC_RET = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    STEP,
    SETTLE
  } fetch_state_e;

endpackage

// File: rtl/instr_predecode.sv
// Combinational opcode predecode: flags JSR/RET and extracts the relative offset.
module instr_predecode
  import fetch_pkg::*;
#(
  parameter int         INSTR_W = DEF_INSTR_W,
  parameter int         OFS_W   = DEF_OFS_W,
  parameter logic [3:0] OPC_JSR = DEF_OPC_JSR,
  parameter logic [3:0] OPC_RET = DEF_OPC_RET
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               is_jsr,
  output logic               is_ret,
  output logic [OFS_W-1:0]   ofs
);

  logic [3:0] opcode;
  // Bits between the opcode field and the offset carry nothing for fetch.
  logic       unused_mid_bits;

  always_comb begin
    opcode = instr[INSTR_W-1 -: 4];
    is_jsr = (opcode == OPC_JSR);
    is_ret = (opcode == OPC_RET);
    ofs    = instr[OFS_W-1:0];
  end

  assign unused_mid_bits = ^instr[INSTR_W-5:OFS_W];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads the word at pc, offers it to decode, then strobes the
// program counter with the matching jsr/ret/relative_addr qualifiers.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int         ADDR_W  = DEF_ADDR_W,
  parameter int         INSTR_W = DEF_INSTR_W,
  parameter int         OFS_W   = DEF_OFS_W,
  parameter logic [3:0] OPC_JSR = DEF_OPC_JSR,
  parameter logic [3:0] OPC_RET = DEF_OPC_RET
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               pc_step,
  output logic               jsr,
  output logic               ret,
  output logic [OFS_W-1:0]   relative_addr,
  output logic [15:0]        retired
);

  fetch_state_e       state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pc_step_q, pc_step_d;
  logic               jsr_q, jsr_d;
  logic               ret_q, ret_d;
  logic [OFS_W-1:0]   rel_addr_q, rel_addr_d;
  logic [15:0]        retired_q, retired_d;
  logic               handshake;
  logic               dec_jsr, dec_ret;
  logic [OFS_W-1:0]   dec_ofs;

  instr_predecode #(
    .INSTR_W (INSTR_W),
    .OFS_W   (OFS_W),
    .OPC_JSR (OPC_JSR),
    .OPC_RET (OPC_RET)
  ) u_predecode (
    .instr  (instr_q),
    .is_jsr (dec_jsr),
    .is_ret (dec_ret),
    .ofs    (dec_ofs)
  );

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_step_d     = 1'b0;
    jsr_d         = 1'b0;
    ret_d         = 1'b0;
    rel_addr_d    = '0;
    retired_d     = retired_q;
    handshake     = instr_valid_q && instr_ready;

    if (flush) begin
      // Preload in progress: drop everything and wait in REQ with the request low.
      state_d       = REQ;
      mem_req_d     = 1'b0;
      instr_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (!mem_req_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc;
          end else if (mem_ack) begin
            instr_d       = mem_rdata;
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            instr_valid_d = 1'b0;
            pc_step_d     = 1'b1;
            jsr_d         = dec_jsr;
            ret_d         = dec_ret;
            rel_addr_d    = dec_ofs;
            if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
            state_d       = STEP;
          end
        end
        STEP:    state_d = SETTLE;
        SETTLE:  state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_step_q     <= 1'b0;
      jsr_q         <= 1'b0;
      ret_q         <= 1'b0;
      rel_addr_q    <= '0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_step_q     <= pc_step_d;
      jsr_q         <= jsr_d;
      ret_q         <= ret_d;
      rel_addr_q    <= rel_addr_d;
      retired_q     <= retired_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign instr_valid   = instr_valid_q;
  assign instr         = instr_q;
  assign pc_step       = pc_step_q;
  assign jsr           = jsr_q;
  assign ret           = ret_q;
  assign relative_addr = rel_addr_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// memory latency, decode back-pressure and flushes against a transaction model.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [10:0] pc;
  logic        flush;
  logic        mem_req;
  logic [10:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        pc_step;
  logic        jsr;
  logic        ret;
  logic [9:0]  relative_addr;
  logic [15:0] retired;

  instr_fetch dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc            (pc),
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .pc_step       (pc_step),
    .jsr           (jsr),
    .ret           (ret),
    .relative_addr (relative_addr),
    .retired       (retired)
  );

  always #5 clock = ~clock;

  // Program memory and the call stack of the program counter the bench plays.
  logic [15:0] mem [2048];
  logic [10:0] stack [$];

  int          ack_dly, rdy_dly, req_age, val_age, steps;
  int          n_checks, n_fail;
  bit          exp_step, exp_valid, req_low, was_req;
  logic [15:0] step_word, held_word, exp_retired;
  logic [10:0] req_addr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_step    = 1'b0;
    exp_valid   = 1'b0;
    exp_retired = 16'h0;
    req_age     = 0;
    val_age     = 0;
    stack.delete();
  endtask

  // One clock: predict from the inputs now driven, check after the edge, then
  // let the memory, decode and counter models drive the next inputs.
  task automatic tick();
    bit hs, acc;
    hs  = instr_valid && instr_ready && !flush;
    acc = mem_req && mem_ack && !flush;
    exp_step = hs;
    if (hs) begin
      step_word = held_word;
      exp_valid = 1'b0;
      if (exp_retired != 16'hFFFF) exp_retired = exp_retired + 16'd1;
    end
    if (acc) begin
      exp_valid = 1'b1;
      held_word = mem_rdata;
    end
    if (flush) exp_valid = 1'b0;
    req_low = flush || acc;
    was_req = mem_req;

    @(negedge clock);
    if (exp_step) begin
      check("step", pc_step, 1);
      check("jsr", jsr, step_word[15:12] == 4'hE);
      check("ret", ret, step_word[15:12] == 4'hF);
      check("rel_addr", relative_addr, step_word[9:0]);
    end else begin
      check("no_step", {pc_step, jsr, ret}, 0);
    end
    check("retired", retired, exp_retired);
    check("valid", instr_valid, exp_valid);
    if (exp_valid) check("instr", instr, held_word);
    if (req_low) check("req_low", mem_req, 0);
    else if (was_req) check("req_hold", {mem_req, mem_addr}, {1'b1, req_addr});
    else if (mem_req) begin
      check("req_addr", mem_addr, pc);
      req_addr = pc;
    end

    if (pc_step) begin
      steps++;
      if (jsr) begin
        if (stack.size() < 32) stack.push_back(pc + 11'd1);
        pc = pc + 11'(relative_addr);
      end else if (ret && stack.size() > 0) begin
        pc = stack.pop_back();
      end else begin
        pc = pc + 11'd1;
      end
    end
    if (mem_req && req_age >= ack_dly) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      req_age   = 0;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      req_age   = mem_req ? req_age + 1 : 0;
    end
    if (instr_valid) begin
      instr_ready = (val_age >= rdy_dly);
      val_age++;
    end else begin
      instr_ready = 1'($urandom_range(0, 1));
      val_age     = 0;
    end
  endtask

  // what: 0 = mem_req high, 1 = instr_valid high, 2 = pc_step high.
  task automatic tick_until(input int what, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      case (what)
        0:       hit = mem_req;
        1:       hit = instr_valid;
        default: hit = pc_step;
      endcase
    end
    check({tag, "_timeout"}, 64'(hit), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; steps = 0;
    reset_n = 1'b0; pc = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; ack_dly = 0; rdy_dly = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    reset_model();
    repeat (2) @(negedge clock);
    check("rst_outputs", {mem_req, mem_addr, instr_valid, instr, pc_step, jsr, ret,
                          relative_addr, retired}, 0);

    // Plain instruction at pc 0, memory answers two cycles late.
    mem[0] = 16'h1234; ack_dly = 2;
    reset_n = 1'b1;
    tick_until(0, 10, "t1_req");
    check("t1_addr", mem_addr, 11'd0);
    tick_until(1, 10, "t1_valid");
    check("t1_instr", instr, 16'h1234);
    tick_until(2, 10, "t1_step");
    check("t1_jsr_ret", {jsr, ret}, 2'b00);
    check("t1_retired", retired, 16'd1);

    // JSR at pc 5 jumps to 15, where a RET waits with decode stalled.
    pc = 11'd5; mem[5] = 16'hE00A; mem[15] = 16'hF000; ack_dly = 0;
    tick_until(2, 20, "t2_step");
    check("t2_jsr", {jsr, ret}, 2'b10);
    check("t2_rel", relative_addr, 10'h00A);
    rdy_dly = 7;
    tick_until(0, 10, "t2_req");
    check("t2_next_addr", mem_addr, 11'd15);
    tick_until(1, 10, "t3_valid");
    repeat (6) begin
      tick();
      check("t3_hold_instr", instr, 16'hF000);
      check("t3_no_step", pc_step, 0);
    end
    tick_until(2, 5, "t3_step");
    check("t3_ret", {jsr, ret}, 2'b01);

    // Flush lands on the same edge as the memory acknowledge.
    rdy_dly = 0;
    tick_until(0, 10, "t4_req");
    flush = 1'b1; pc = 11'h400; mem[11'h400] = 16'h0042;
    tick();
    check("t4_discard", {instr_valid, mem_req}, 0);
    tick(); tick();
    check("t4_hold_low", mem_req, 0);
    flush = 1'b0;
    tick_until(0, 5, "t4_req2");
    check("t4_addr", mem_addr, 11'h400);

    // Flush and decode handshake on the same edge: flush wins.
    tick_until(1, 10, "t4b_valid");
    flush = 1'b1;
    tick();
    check("t4b_no_step", pc_step, 0);
    check("t4b_retired", retired, 16'd3);
    flush = 1'b0;
    tick_until(2, 20, "t4b_step");

    // Retired counter saturation.
    tick_until(2, 20, "t5_pre");
    force dut.retired_q = 16'hFFFE;
    exp_retired = 16'hFFFE;
    tick();
    release dut.retired_q;
    repeat (3) tick_until(2, 30, "t5_step");
    check("t5_sat", retired, 16'hFFFF);

    // Asynchronous reset while an instruction is held, then a stale acknowledge.
    rdy_dly = 20;
    tick_until(1, 20, "t6_valid");
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_rst", {mem_req, mem_addr, instr_valid, instr, pc_step, jsr, ret,
                           relative_addr, retired}, 0);
    reset_model();
    @(negedge clock);
    reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD; instr_ready = 1'b0;
    mem[pc] = 16'h1357; rdy_dly = 0;
    tick();
    check("t6_stale_ignored", {instr_valid, mem_req}, 0);
    tick_until(0, 5, "t6_req");
    check("t6_addr", mem_addr, pc);
    tick_until(1, 10, "t6_valid2");
    check("t6_instr", instr, 16'h1357);

    // Random program with biased JSR/RET density, latency, stalls and flushes.
    for (int i = 0; i < 2048; i++) begin
      case ($urandom_range(0, 3))
        0:       mem[i] = {4'hE, 12'($urandom)};
        1:       mem[i] = {4'hF, 12'($urandom)};
        default: mem[i] = 16'($urandom);
      endcase
    end
    steps = 0;
    for (int n = 0; n < 4000; n++) begin
      ack_dly = $urandom_range(0, 3);
      rdy_dly = $urandom_range(0, 3);
      if (flush) flush = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 49) == 0) begin
        flush = 1'b1;
        pc    = 11'($urandom);
      end
      tick();
    end
    flush = 1'b0;
    tick();
    check("rand_progress", 64'(steps >= 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly downstream of the program counter. Each instruction:
- reads the word at the current pc from program memory over a req/ack handshake;
- holds it in an instruction register and offers it to decode over a valid/ready handshake;
- decodes JSR/RET, then issues a one-cycle step strobe with the matching jsr/ret/relative_addr controls that advance the counter.

Parameters:
ADDR_W, 11, program address width (matches pc)
INSTR_W, 16, instruction word width
OFS_W, 10, JSR relative-offset width
OPC_JSR, 4'hE, opcode field value for JSR
OPC_RET, 4'hF, opcode field value for RET

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
pc  input  ADDR_W  current program counter
flush  input  1  abort current fetch (preload in progress)
mem_req  output  1  program-memory read request
mem_addr  output  ADDR_W  read address
mem_ack  input  1  read done; mem_rdata valid this cycle
mem_rdata  input  INSTR_W  read data
instr_valid  output  1  instruction register holds an instruction for decode
instr_ready  input  1  decode accepts instruction
instr  output  INSTR_W  instruction register
pc_step  output  1  one-cycle strobe: counter advances
jsr  output  1  qualifies pc_step: jump-to-subroutine
ret  output  1  qualifies pc_step: return
relative_addr  output  OFS_W  JSR offset, instr[OFS_W-1:0]
retired  output  16  count of accepted instructions, saturating

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0: mem_req, mem_addr, instr_valid, instr, pc_step, jsr, ret, relative_addr, retired.
- Reset mid-operation: an outstanding memory read is abandoned; a mem_ack arriving after release while in IDLE is ignored.
- FSM states and transitions:
  - IDLE: go to REQ next cycle.
  - REQ:
    - mem_req=1, mem_addr=pc, both registered and stable until ack.
    - On mem_ack: instr<=mem_rdata, mem_req<=0, go to HOLD.
    - Ack may arrive in the first cycle mem_req is high.
  - HOLD:
    - instr_valid=1; instr stable until handshake.
    - On instr_valid&&instr_ready: instr_valid<=0, go to STEP.
  - STEP: exactly one cycle.
    - pc_step=1.
    - jsr=1 if instr[INSTR_W-1:INSTR_W-4]==OPC_JSR.
    - ret=1 if that field==OPC_RET.
    - relative_addr=instr[OFS_W-1:0], zero-extended by the counter.
    - jsr and ret are never both 1; both are 0 outside STEP.
    - Go to SETTLE.
  - SETTLE: one cycle for the counter to update; go to REQ, which samples the new pc.
- Throughput: minimum 5 cycles per instruction, i.e. REQ(1) + HOLD(1) + STEP(1) + SETTLE(1) + registered request issue.
- retired:
  - increments by 1 on each valid&&ready handshake;
  - saturates at 16'hFFFF;
  - cleared only by reset.
- flush=1 in any state:
  - next state REQ; instr_valid<=0; pc_step/jsr/ret<=0.
  - Any in-flight mem_ack in that cycle is discarded.
  - While flush stays high, stay in REQ with mem_req=0.
  - On the first cycle flush=0, raise mem_req with mem_addr=pc.
- flush and a valid&&ready handshake in the same cycle: flush wins; retired not incremented; no pc_step.
- mem_ack outside REQ: ignored.
- pc wrap (2047 -> 0) is handled by the counter; fetch only presents the pc value it samples.
- Each field is fixed by its own bits; no field is derived from the others.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, REQ, HOLD, STEP, SETTLE};
  - opcode constants OPC_JSR, OPC_RET;
  - ADDR_W/INSTR_W/OFS_W defaults.
- One natural sub-module, instr_predecode: combinational opcode -> {is_jsr, is_ret, ofs}, reused by later decode.
- FSM, registers and counter stay in instr_fetch.

Test Plan:
- Reset then pc=0, memory returns 16'h1234 with ack 2 cycles after req -> mem_addr=0; instr=16'h1234, instr_valid=1; after ready, one pc_step with jsr=0, ret=0; retired=1.
- pc=5, mem_rdata=16'hE00A -> STEP cycle shows pc_step=1, jsr=1, relative_addr=10'h00A; next REQ uses the updated pc=15.
- mem_rdata=16'hF000 -> pc_step=1, ret=1, jsr=0; instr_ready held low 7 cycles -> instr stable, no pc_step until ready.
- flush asserted while in REQ with mem_ack the same cycle, pc preloaded to 11'h400 -> ack data discarded, no instr_valid; after flush drops, mem_addr=11'h400.
- Force retired to 16'hFFFE, run 3 handshakes -> retired ends at 16'hFFFF.
- reset_n pulsed low mid-HOLD -> all outputs 0 asynchronously; a stale mem_ack after release is ignored; fetch restarts at the current pc.
